// File: rtl/updown_counter_mod_pkg.sv
// updown_counter_mod_pkg: direction/mode encodings and sizing helper shared by the counter slice.
package updown_counter_mod_pkg;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/updown_counter_mod_prescaler.sv
// cnt_prescaler: emits one step per PRESCALE enabled cycles; sync_clr restarts the period.
module cnt_prescaler
   import updown_counter_mod_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic step
);
   localparam int CW = clog2(PRESCALE) < 1 ? 1 : clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
   logic [CW-1:0] cnt;
   // With PRESCALE=1 cnt never leaves 0, so step reduces to en.
   assign step = en && cnt == LAST;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (sync_clr || step) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: modulo up/down counter with wrap/saturate, clamped load,
// prescaled stepping, terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_mod
   import updown_counter_mod_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 2**WIDTH - 1,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             s,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] y,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);
   if (WIDTH < 1 || MAX_VAL < 0 || MAX_VAL > 2**WIDTH - 1 || PRESCALE < 1) begin : g_bad_params
      $error("updown_counter_mod: illegal WIDTH/MAX_VAL/PRESCALE");
   end
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
   logic             pre_step, stp, up, hold, bnd;
   logic [WIDTH-1:0] y_nxt;
   cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync_clr (load),
      .step     (pre_step)
   );
   // Boundary is decided on the current count before any +/-1, so y never exceeds MAXV.
   always_comb begin
      stp   = pre_step && !load;
      up    = s == DIR_UP;
      hold  = sat == MODE_SAT;
      bnd   = stp && (up ? y == MAXV : y == '0);
      y_nxt = load ? (load_val > MAXV ? MAXV : load_val) :
              !stp ? y :
              bnd  ? (hold ? y : up ? '0 : MAXV) :
              up   ? y + 1'b1 : y - 1'b1;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         y   <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         y   <= y_nxt;
         tc  <= bnd;
         ovf <= (bnd && up) || (ovf && !clr_flags);
         unf <= (bnd && !up) || (unf && !clr_flags);
      end
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: directed scoreboard bench; stimulus queues expected outputs,
// a monitor pops and compares them after each edge (or on demand after an async reset).
module tb_updown_counter_mod;
   logic       clk = 0, rst = 1, en = 0, s = 0, sat = 0, load = 0, clr_flags = 0;
   logic [3:0] load_val = 0;
   logic [3:0] y1, y3;
   logic       tc1, ovf1, unf1, tc3, ovf3, unf3;
   int         checks = 0, errors = 0;
   typedef struct {
      string      nm;
      bit         d3;
      logic [3:0] y;
      logic       tc, o, u;
   } exp_t;
   exp_t q[$];
   event smp;

   updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) d1 (
      .clk(clk), .rst(rst), .en(en), .s(s), .sat(sat), .load(load), .load_val(load_val),
      .clr_flags(clr_flags), .y(y1), .tc(tc1), .ovf(ovf1), .unf(unf1));
   updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) d3 (
      .clk(clk), .rst(rst), .en(en), .s(s), .sat(sat), .load(load), .load_val(load_val),
      .clr_flags(clr_flags), .y(y3), .tc(tc3), .ovf(ovf3), .unf(unf3));

   always #5 clk = ~clk;
   always begin
      @(posedge clk);
      #1 -> smp;
   end

   initial forever begin
      @(smp);
      if (q.size() != 0) begin
         exp_t e;
         logic [6:0] act, want;
         e    = q.pop_front();
         act  = e.d3 ? {y3, tc3, ovf3, unf3} : {y1, tc1, ovf1, unf1};
         want = {e.y, e.tc, e.o, e.u};
         checks++;
         if (act !== want) begin
            errors++;
            $display("FAIL %s got y=%0d tc=%b ovf=%b unf=%b want y=%0d tc=%b ovf=%b unf=%b",
                     e.nm, act[6:3], act[2], act[1], act[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic cyc(input string nm, input logic r, e, sv, st, ld, input logic [3:0] lv,
                      input logic cf, input bit d, input logic [3:0] ey, input logic et, eo, eu);
      @(negedge clk);
      rst = r; en = e; s = sv; sat = st; load = ld; load_val = lv; clr_flags = cf;
      q.push_back('{nm, d, ey, et, eo, eu});
   endtask

   initial begin
      logic [3:0] my, lv;
      logic       mt, mo, mu, re, rs, rt, rl, rc;
      cyc("rst_d1", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("rst_d3", 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 12; k++)
         cyc($sformatf("up_wrap_%0d", k), 0, 1, 1, 0, 0, 0, 0, 0, 4'(k % 10), k == 10, k >= 10, 0);
      cyc("load_zero", 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      repeat (3) cyc("down_sat", 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
      cyc("load_clamp", 0, 1, 0, 0, 1, 15, 0, 0, 9, 0, 1, 1);
      cyc("set_wins", 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0);
      cyc("clr_flags", 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("down_wrap", 0, 1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 1);
      cyc("down_step", 0, 1, 0, 0, 0, 0, 0, 0, 8, 0, 0, 1);
      cyc("pre_rst", 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 9; k++)
         cyc($sformatf("pre_%0d", k), 0, 1, 1, 0, 0, 0, 0, 1, 4'(k / 3), 0, 0, 0);
      cyc("pre_10", 0, 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
      cyc("pre_gap1", 0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
      cyc("pre_gap2", 0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
      cyc("pre_13", 0, 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
      cyc("pre_shift", 0, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
      cyc("pre_15", 0, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
      cyc("pre_16", 0, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
      cyc("pre_17", 0, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      cyc("pre_18", 0, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      @(posedge clk);
      #3 rst = 1;
      #1 q.push_back('{"async_d3", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
      -> smp;
      #1 q.push_back('{"async_d1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
      -> smp;
      cyc("post_rst_1", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc("post_rst_2", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc("post_rst_3", 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      cyc("rnd_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      my = 0; mo = 0; mu = 0;
      for (int k = 0; k < 2000; k++) begin
         re = 1'($urandom_range(0, 3) != 0);
         rs = 1'($urandom);
         rt = 1'($urandom);
         rl = 1'($urandom_range(0, 7) == 0);
         rc = 1'($urandom_range(0, 7) == 0);
         lv = 4'($urandom);
         mt = 0;
         if (rl) my = lv > 9 ? 4'd9 : lv;
         else if (re && rs) begin
            mt = my == 9;
            my = my == 9 ? (rt ? 4'd9 : 4'd0) : my + 4'd1;
         end else if (re) begin
            mt = my == 0;
            my = my == 0 ? (rt ? 4'd0 : 4'd9) : my - 4'd1;
         end
         mo = (mt && rs) || (mo && !rc);
         mu = (mt && !rs) || (mu && !rc);
         cyc("random", 0, re, rs, rt, rl, lv, rc, 0, my, mt, mo, mu);
      end
      repeat (2) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors += q.size();
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
